// File: rtl/game_input_arbiter_if.sv
// Bundle between the input decoders / game_core and the input arbiter.
interface game_input_arbiter_if;
   logic       left;
   logic       right;
   logic       retract;
   logic       retry;
   logic [7:0] key;
   logic       key_valid;
   logic [5:0] cursor;
   logic       click;
   logic       game_area;
   logic [5:0] man;
   logic       win;
   logic       lose;
   logic       mv_go;
   logic [1:0] mv_dir;
   logic       retract_go;
   logic       retry_go;
   logic       stage_prev_go;
   logic       stage_next_go;
   logic [2:0] pending;
   logic       dropped;

   // Source side: drives requests and game status, observes commands.
   modport master (
      output left, right, retract, retry, key, key_valid, cursor, click, game_area,
             man, win, lose,
      input  mv_go, mv_dir, retract_go, retry_go, stage_prev_go, stage_next_go,
             pending, dropped
   );

   // Arbiter side.
   modport slave (
      input  left, right, retract, retry, key, key_valid, cursor, click, game_area,
             man, win, lose,
      output mv_go, mv_dir, retract_go, retry_go, stage_prev_go, stage_next_go,
             pending, dropped
   );
endinterface

// File: rtl/game_input_arbiter.sv
// Player input arbiter: edge-detects buttons, keyboard codes and board clicks,
// prioritises and gates them, queues them in a 4-entry FIFO and issues one
// single-cycle command at a time with a HOLDOFF-cycle pause between commands.
module game_input_arbiter #(
   parameter int unsigned HOLDOFF   = 8,
   parameter logic [7:0]  KEY_UP    = 8'h75,
   parameter logic [7:0]  KEY_DOWN  = 8'h72,
   parameter logic [7:0]  KEY_LEFT  = 8'h6B,
   parameter logic [7:0]  KEY_RIGHT = 8'h74,
   parameter logic [7:0]  KEY_UNDO  = 8'h3C,
   parameter logic [7:0]  KEY_RETRY = 8'h2D
) (
   input logic                 clk,
   input logic                 reset,
   game_input_arbiter_if.slave bus
);

   typedef enum logic [2:0] {
      CMD_UP, CMD_DOWN, CMD_LEFT, CMD_RIGHT, CMD_RETRACT, CMD_RETRY, CMD_PREV, CMD_NEXT
   } cmd_t;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_t;

   localparam logic [7:0] HOLD_INIT = 8'(HOLDOFF - 1);

   logic       left_q, right_q, retract_q, retry_q, click_q;
   logic       rise_left, rise_right, rise_retract, rise_retry, rise_click;
   logic       key_hit;
   cmd_t       key_cmd;
   logic       adj_hit;
   cmd_t       adj_cmd;
   logic [3:0] c_row, c_col, m_row, m_col;
   logic [5:0] cand;
   logic       multi, win_valid, is_move, flush, push, drop_d;
   cmd_t       win_cmd;
   cmd_t       fifo_q [4];
   cmd_t       head;
   logic [1:0] rd_ptr_q, rd_ptr_d, wr_idx;
   logic [2:0] count_q, count_d;
   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       pop;
   cmd_t       cmd_q;
   logic [1:0] mv_dir_q;
   logic       dropped_q;

   assign rise_left    = bus.left    & ~left_q;
   assign rise_right   = bus.right   & ~right_q;
   assign rise_retract = bus.retract & ~retract_q;
   assign rise_retry   = bus.retry   & ~retry_q;
   assign rise_click   = bus.click   & ~click_q;

   // One extra bit so that row/column 0 minus one cannot wrap onto row/column 7.
   assign c_row = {1'b0, bus.cursor[5:3]};
   assign c_col = {1'b0, bus.cursor[2:0]};
   assign m_row = {1'b0, bus.man[5:3]};
   assign m_col = {1'b0, bus.man[2:0]};

   // Keyboard code match; unknown codes are simply not requests.
   always_comb begin
      key_hit = bus.key_valid;
      key_cmd = CMD_UP;
      case (bus.key)
         KEY_UP:    key_cmd = CMD_UP;
         KEY_DOWN:  key_cmd = CMD_DOWN;
         KEY_LEFT:  key_cmd = CMD_LEFT;
         KEY_RIGHT: key_cmd = CMD_RIGHT;
         KEY_UNDO:  key_cmd = CMD_RETRACT;
         KEY_RETRY: key_cmd = CMD_RETRY;
         default:   key_hit = 1'b0;
      endcase
   end

   // Mouse click: valid only inside the board and 4-adjacent to the man.
   always_comb begin
      adj_hit = 1'b0;
      adj_cmd = CMD_UP;
      if (c_col == m_col && c_row + 4'd1 == m_row) begin
         adj_hit = 1'b1;
         adj_cmd = CMD_UP;
      end else if (c_col == m_col && c_row == m_row + 4'd1) begin
         adj_hit = 1'b1;
         adj_cmd = CMD_DOWN;
      end else if (c_row == m_row && c_col + 4'd1 == m_col) begin
         adj_hit = 1'b1;
         adj_cmd = CMD_LEFT;
      end else if (c_row == m_row && c_col == m_col + 4'd1) begin
         adj_hit = 1'b1;
         adj_cmd = CMD_RIGHT;
      end
      adj_hit = adj_hit & bus.game_area;
   end

   // Pick one winner, gate it by game status and FIFO space, flag every discard.
   always_comb begin
      cand      = {rise_retry, rise_retract, rise_right, rise_left, key_hit, rise_click & adj_hit};
      multi     = (cand & (cand - 6'd1)) != '0;
      win_valid = cand != '0;
      win_cmd   = adj_cmd;
      if (rise_retry)        win_cmd = CMD_RETRY;
      else if (rise_retract) win_cmd = CMD_RETRACT;
      else if (rise_right)   win_cmd = CMD_NEXT;
      else if (rise_left)    win_cmd = CMD_PREV;
      else if (key_hit)      win_cmd = key_cmd;
      is_move = win_valid & ~win_cmd[2];
      flush   = win_valid & (win_cmd == CMD_RETRY || win_cmd == CMD_PREV || win_cmd == CMD_NEXT);
      push    = win_valid & ~(is_move & (bus.win | bus.lose)) & (flush | (count_q != 3'd4));
      drop_d  = (rise_click & ~adj_hit) | multi | (win_valid & ~push);
   end

   // FIFO pointer/occupancy update; a flush restarts the queue with only the new entry.
   always_comb begin
      rd_ptr_d = rd_ptr_q + {1'b0, pop};
      count_d  = count_q + {2'b0, push} - {2'b0, pop};
      wr_idx   = rd_ptr_q + count_q[1:0];
      if (flush) begin
         rd_ptr_d = '0;
         count_d  = 3'd1;
         wr_idx   = '0;
      end
   end

   assign head = fifo_q[rd_ptr_q];

   // Edge registers, FIFO control, command register, last move direction, drop pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         left_q    <= 1'b0;
         right_q   <= 1'b0;
         retract_q <= 1'b0;
         retry_q   <= 1'b0;
         click_q   <= 1'b0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         cmd_q     <= CMD_UP;
         mv_dir_q  <= '0;
         dropped_q <= 1'b0;
      end else begin
         left_q    <= bus.left;
         right_q   <= bus.right;
         retract_q <= bus.retract;
         retry_q   <= bus.retry;
         click_q   <= bus.click;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         dropped_q <= drop_d;
         if (pop) begin
            cmd_q <= head;
            if (!head[2]) mv_dir_q <= head[1:0];
         end
      end
   end

   // FIFO storage; occupancy qualifies every read, so no reset is needed.
   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_idx] <= win_cmd;
   end

   // Issue FSM state and hold-off counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Issue FSM next state: pop when idle, one issue cycle, then count down the hold-off.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d = S_HOLD;
            cnt_d   = HOLD_INIT;
         end
         S_HOLD: begin
            if (cnt_q == '0) state_d = S_IDLE;
            else             cnt_d   = cnt_q - 8'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Issue FSM outputs: decode the command register during the issue cycle.
   always_comb begin
      bus.mv_go         = 1'b0;
      bus.retract_go    = 1'b0;
      bus.retry_go      = 1'b0;
      bus.stage_prev_go = 1'b0;
      bus.stage_next_go = 1'b0;
      if (state_q == S_ISSUE) begin
         case (cmd_q)
            CMD_RETRACT: bus.retract_go    = 1'b1;
            CMD_RETRY:   bus.retry_go      = 1'b1;
            CMD_PREV:    bus.stage_prev_go = 1'b1;
            CMD_NEXT:    bus.stage_next_go = 1'b1;
            default:     bus.mv_go         = 1'b1;
         endcase
      end
   end

   assign bus.mv_dir  = mv_dir_q;
   assign bus.pending = count_q;
   assign bus.dropped = dropped_q;

endmodule
